// File: rtl/param_lifo_stack_pkg.sv
// Shared types and helpers for the parametrised LIFO stack.
// Build option: LIFO_WATERMARK_EN adds the almost_full watermark output.
package lifo_pkg;

   typedef enum logic [1:0] {
      OP_NONE,
      OP_PUSH,
      OP_POP,
      OP_REPLACE
   } lifo_op_t;

   // Occupancy counter width: one extra bit so that DEPTH itself is representable.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/param_lifo_stack_if.sv
// Request/status bundle of the LIFO stack; master drives requests, slave is the stack.
// Build option: LIFO_WATERMARK_EN adds almost_full to the bundle.
interface param_lifo_stack_if
   import lifo_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
);
   logic                      clear;
   logic                      push;
   logic                      pop;
   logic [WIDTH-1:0]          din;
   logic [WIDTH-1:0]          top;
   logic [cnt_w(DEPTH)-1:0]   count;
   logic                      full;
   logic                      empty;
   logic                      overflow;
   logic                      underflow;
`ifdef LIFO_WATERMARK_EN
   logic                      almost_full;
`endif

   modport master (
      output clear, push, pop, din,
      input  top, count, full, empty, overflow, underflow
`ifdef LIFO_WATERMARK_EN
      , input almost_full
`endif
   );

   modport slave (
      input  clear, push, pop, din,
      output top, count, full, empty, overflow, underflow
`ifdef LIFO_WATERMARK_EN
      , output almost_full
`endif
   );

endinterface

// File: rtl/param_lifo_stack_storage.sv
// LIFO entry array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module lifo_storage #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/param_lifo_stack.sv
// Parametrised LIFO stack with registered occupancy count and one-cycle error pulses.
// Build option: LIFO_WATERMARK_EN enables almost_full (count >= AFULL_THRESH).
module param_lifo_stack
   import lifo_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int DEPTH        = 16,
   parameter int AFULL_THRESH = 12
) (
   input  logic                clk,
   input  logic                rst,
   param_lifo_stack_if.slave   bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
      $error("DEPTH must be a power of two >= 2");
   end
   if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_thresh_chk
      $error("AFULL_THRESH must lie in 1..DEPTH");
   end

   logic [CW-1:0]    cnt_q;
   logic             ovf_q, unf_q;
   logic             ovf_d, unf_d;
   logic             is_empty, is_full;
   lifo_op_t         op;
   logic             we;
   logic [AW-1:0]    wr_idx, top_idx;
   logic [WIDTH-1:0] rdata;

   assign is_empty = (cnt_q == '0);
   assign is_full  = (cnt_q == CW'(DEPTH));

   // clear wins over everything; a push+pop on an empty stack degrades to a push.
   always_comb begin
      op    = OP_NONE;
      ovf_d = 1'b0;
      unf_d = 1'b0;
      if (bus.clear) begin
         op = OP_NONE;
      end else if (bus.push && bus.pop) begin
         if (!is_empty) begin
            op = OP_REPLACE;
         end else begin
            op    = OP_PUSH;
            unf_d = 1'b1;
         end
      end else if (bus.push) begin
         if (!is_full) op = OP_PUSH;
         else          ovf_d = 1'b1;
      end else if (bus.pop) begin
         if (!is_empty) op = OP_POP;
         else           unf_d = 1'b1;
      end
   end

   // With count == DEPTH the low AW bits are zero, so the -1 wraps to DEPTH-1 as intended.
   assign top_idx = cnt_q[AW-1:0] - AW'(1);
   assign we      = (op == OP_PUSH) || (op == OP_REPLACE);
   assign wr_idx  = (op == OP_REPLACE) ? top_idx : cnt_q[AW-1:0];

   lifo_storage #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_storage (
      .clk   (clk),
      .we    (we),
      .waddr (wr_idx),
      .wdata (bus.din),
      .raddr (top_idx),
      .rdata (rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
         if (bus.clear) begin
            cnt_q <= '0;
         end else if (op == OP_PUSH) begin
            cnt_q <= cnt_q + CW'(1);
         end else if (op == OP_POP) begin
            cnt_q <= cnt_q - CW'(1);
         end
      end
   end

   assign bus.top       = is_empty ? '0 : rdata;
   assign bus.count     = cnt_q;
   assign bus.full      = is_full;
   assign bus.empty     = is_empty;
   assign bus.overflow  = ovf_q;
   assign bus.underflow = unf_q;
`ifdef LIFO_WATERMARK_EN
   assign bus.almost_full = (cnt_q >= CW'(AFULL_THRESH));
`endif

endmodule
